// File: rtl/hot_water_arbiter_if.sv
// Request/grant bundle between the washing-machine controllers and the shared hot-water arbiter.
// master = controller side (drives req), slave = arbiter side.
interface hot_water_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [1:0]       grant_id;
  logic             busy;
  logic             heater_on;
  logic             timeout;

  modport master (
    output req,
    input  grant,
    input  grant_id,
    input  busy,
    input  heater_on,
    input  timeout
  );

  modport slave (
    input  req,
    output grant,
    output grant_id,
    output busy,
    output heater_on,
    output timeout
  );
endinterface

// File: rtl/hot_water_arbiter.sv
// Round-robin arbiter for one shared hot-water inlet/heater, with capped grants and heater recovery.
// Optional HWA_TIMEOUT_STATS_EN adds a saturating timeout counter (timeout_count) with clr_stats.
//
// state   | meaning
// IDLE    | no grant; pick next requester round-robin from pointer+1
// GRANT   | one requester holds the inlet; timer counts held cycles up to MAX_GRANT
// RECOVER | heater recovery; requests ignored until timer reaches RECOVERY
module hot_water_arbiter #(
  parameter int         N_REQ     = 4,
  parameter logic [7:0] MAX_GRANT = 8'd16,
  parameter logic [7:0] RECOVERY  = 8'd4
) (
  input  logic clk,
  input  logic rst,
`ifdef HWA_TIMEOUT_STATS_EN
  input  logic       clr_stats,
  output logic [7:0] timeout_count,
`endif
  hot_water_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, RECOVER} state_t;

  state_t           state;
  logic [N_REQ-1:0] grant_r;
  logic [1:0]       grant_id_r;
  logic [1:0]       ptr;
  logic             busy_r;
  logic             heater_r;
  logic             timeout_r;
  logic [7:0]       timer;

  logic [N_REQ-1:0] req_v;
  logic [N_REQ-1:0] win_oh;
  logic [1:0]       winner;
  logic             found;
  logic             any_req;
  logic             g_req;

  assign req_v   = bus.req;
  assign any_req = |req_v;
  // the granted requester's level, without indexing by a possibly narrower id
  assign g_req   = |(req_v & grant_r);

  // first pass covers indices above the pointer, second wraps to 0..pointer
  always_comb begin
    win_oh = '0;
    winner = '0;
    found  = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req_v[j] && (j > int'(ptr))) begin
        found     = 1'b1;
        win_oh[j] = 1'b1;
        winner    = 2'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req_v[j] && (j <= int'(ptr))) begin
        found     = 1'b1;
        win_oh[j] = 1'b1;
        winner    = 2'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant_r    <= '0;
      grant_id_r <= '0;
      ptr        <= 2'(N_REQ - 1);
      busy_r     <= 1'b0;
      heater_r   <= 1'b0;
      timeout_r  <= 1'b0;
      timer      <= '0;
    end else begin
      timeout_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state      <= GRANT;
            grant_r    <= win_oh;
            grant_id_r <= winner;
            ptr        <= winner;
            timer      <= 8'd1;
            busy_r     <= 1'b1;
          end
        end
        GRANT: begin
          if (!g_req || (timer == MAX_GRANT)) begin
            // a drop on the cap cycle counts as a normal release
            grant_r   <= '0;
            timeout_r <= g_req;
            timer     <= 8'd1;
            if (RECOVERY == 8'd0) begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end else begin
              state    <= RECOVER;
              heater_r <= 1'b1;
            end
          end else begin
            timer <= timer + 8'd1;
          end
        end
        RECOVER: begin
          if (timer == RECOVERY) begin
            state    <= IDLE;
            busy_r   <= 1'b0;
            heater_r <= 1'b0;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          grant_r  <= '0;
          busy_r   <= 1'b0;
          heater_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant     = grant_r;
  assign bus.grant_id  = grant_id_r;
  assign bus.busy      = busy_r;
  assign bus.heater_on = heater_r;
  assign bus.timeout   = timeout_r;

`ifdef HWA_TIMEOUT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_count <= '0;
    end else if (clr_stats) begin
      timeout_count <= '0;
    end else if (timeout_r && (timeout_count != 8'hFF)) begin
      timeout_count <= timeout_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hot_water_arbiter.sv
// Directed bench for hot_water_arbiter: default instance (4 req, 16/4) plus a 3-req,
// MAX_GRANT=2, RECOVERY=0 instance for wrap and back-to-back timing.
module tb_hot_water_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  hot_water_arbiter_if #(.N_REQ(4)) bus  ();
  hot_water_arbiter_if #(.N_REQ(3)) bus2 ();

`ifdef HWA_TIMEOUT_STATS_EN
  logic       clr_stats;
  logic [7:0] timeout_count;
  logic       clr_stats2;
  logic [7:0] timeout_count2;
`endif

  hot_water_arbiter #(.N_REQ(4), .MAX_GRANT(8'd16), .RECOVERY(8'd4)) u_dut (
    .clk           (clk),
    .rst           (rst),
`ifdef HWA_TIMEOUT_STATS_EN
    .clr_stats     (clr_stats),
    .timeout_count (timeout_count),
`endif
    .bus           (bus.slave)
  );

  hot_water_arbiter #(.N_REQ(3), .MAX_GRANT(8'd2), .RECOVERY(8'd0)) u_dut2 (
    .clk           (clk),
    .rst           (rst),
`ifdef HWA_TIMEOUT_STATS_EN
    .clr_stats     (clr_stats2),
    .timeout_count (timeout_count2),
`endif
    .bus           (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    bus.req  = '0;
    bus2.req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (bus.grant !== 4'b0000) $display("FAIL reset_grant got=%b exp=0000", bus.grant); else n_pass++;
    n_checks++;
    if ({bus.busy, bus.heater_on, bus.timeout} !== 3'b000)
      $display("FAIL reset_flags got=%b exp=000", {bus.busy, bus.heater_on, bus.timeout});
    else n_pass++;
    n_checks++;
    if (bus.grant_id !== 2'd0) $display("FAIL reset_grant_id got=%0d exp=0", bus.grant_id); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    int busy_cnt;
    busy_cnt = 0;
    bus.req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      n_checks++;
      if (bus.grant !== 4'b0001 || bus.grant_id !== 2'd0 || bus.heater_on !== 1'b0)
        $display("FAIL single_grant cyc=%0d got=%b/%0d/%b exp=0001/0/0", i, bus.grant, bus.grant_id, bus.heater_on);
      else n_pass++;
    end
    bus.req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      n_checks++;
      if (bus.grant !== 4'b0000 || bus.heater_on !== 1'b1 || bus.timeout !== 1'b0)
        $display("FAIL single_recover cyc=%0d got=%b/%b/%b exp=0000/1/0", i, bus.grant, bus.heater_on, bus.timeout);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.heater_on !== 1'b0)
      $display("FAIL single_idle got=%b%b exp=00", bus.busy, bus.heater_on);
    else n_pass++;
    n_checks++;
    if (busy_cnt != 7) $display("FAIL single_busy_len got=%0d exp=7", busy_cnt); else n_pass++;
  endtask

  task automatic test_round_robin();
    int cyc;
    int hold;
    int heat;
    logic [3:0] exp_g;
    reset_pulse();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (bus.grant == 4'b0000 && cyc < 10);
      n_checks++;
      if (bus.grant !== exp_g || bus.grant_id !== 2'(k % 4))
        $display("FAIL rr_order k=%0d got=%b/%0d exp=%b/%0d", k, bus.grant, bus.grant_id, exp_g, k % 4);
      else n_pass++;
      if (k == 4) break;
      hold = 0;
      while (bus.grant != 4'b0000 && hold < 40) begin
        @(negedge clk);
        hold++;
      end
      n_checks++;
      if (hold != 16) $display("FAIL rr_hold k=%0d got=%0d exp=16", k, hold); else n_pass++;
      n_checks++;
      if (bus.timeout !== 1'b1 || bus.heater_on !== 1'b1)
        $display("FAIL rr_timeout k=%0d got=%b/%b exp=1/1", k, bus.timeout, bus.heater_on);
      else n_pass++;
      heat = 0;
      while (bus.heater_on && heat < 10) begin
        @(negedge clk);
        heat++;
        if (heat == 1) begin
          n_checks++;
          if (bus.timeout !== 1'b0) $display("FAIL rr_pulse_width k=%0d got=1 exp=0", k); else n_pass++;
        end
      end
      n_checks++;
      if (heat != 4 || bus.busy !== 1'b0)
        $display("FAIL rr_recover k=%0d got=%0d/%b exp=4/0", k, heat, bus.busy);
      else n_pass++;
    end
    bus.req = 4'b0000;
    cyc = 0;
    while (bus.busy && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_no_preempt();
    int cyc;
    reset_pulse();
    bus.req = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (bus.grant !== 4'b0100) $display("FAIL np_first got=%b exp=0100", bus.grant); else n_pass++;
    bus.req = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.grant !== 4'b0100 || bus.grant_id !== 2'd2)
        $display("FAIL np_hold cyc=%0d got=%b/%0d exp=0100/2", i, bus.grant, bus.grant_id);
      else n_pass++;
    end
    bus.req = 4'b1001;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.grant == 4'b0000 && cyc < 20);
    n_checks++;
    if (bus.grant !== 4'b1000 || bus.grant_id !== 2'd3)
      $display("FAIL np_next got=%b/%0d exp=1000/3", bus.grant, bus.grant_id);
    else n_pass++;
    bus.req = 4'b0001;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.grant !== 4'b0001 && cyc < 20);
    n_checks++;
    if (bus.grant !== 4'b0001 || bus.grant_id !== 2'd0)
      $display("FAIL np_wrap got=%b/%0d exp=0001/0", bus.grant, bus.grant_id);
    else n_pass++;
    bus.req = 4'b0000;
    cyc = 0;
    while (bus.busy && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_drop_at_max();
    int heat;
    reset_pulse();
    bus.req = 4'b0001;
    @(negedge clk);
    repeat (15) @(negedge clk);
    n_checks++;
    if (bus.grant !== 4'b0001) $display("FAIL dam_held got=%b exp=0001", bus.grant); else n_pass++;
    bus.req = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (bus.grant !== 4'b0000 || bus.timeout !== 1'b0 || bus.heater_on !== 1'b1)
      $display("FAIL dam_release got=%b/%b/%b exp=0000/0/1", bus.grant, bus.timeout, bus.heater_on);
    else n_pass++;
    heat = 0;
    while (bus.heater_on && heat < 10) begin
      @(negedge clk);
      heat++;
    end
    n_checks++;
    if (heat != 4) $display("FAIL dam_recover got=%0d exp=4", heat); else n_pass++;
  endtask

  task automatic test_reset_mid_grant();
    reset_pulse();
    bus.req = 4'b0001;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.grant !== 4'b0001) $display("FAIL rmg_pre got=%b exp=0001", bus.grant); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.heater_on !== 1'b0)
      $display("FAIL rmg_async got=%b/%b/%b exp=0000/0/0", bus.grant, bus.busy, bus.heater_on);
    else n_pass++;
    bus.req = 4'b0110;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.grant !== 4'b0010 || bus.grant_id !== 2'd1)
      $display("FAIL rmg_after got=%b/%0d exp=0010/1", bus.grant, bus.grant_id);
    else n_pass++;
    bus.req = 4'b0000;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_g  [10];
    logic [1:0] exp_id [10];
    logic       exp_to [10];
    logic       exp_bz [10];
    int cyc;
    exp_g  = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000, 3'b001};
    exp_id = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
    exp_to = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_bz = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    reset_pulse();
    bus2.req = 3'b111;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus2.grant == 3'b000 && cyc < 10);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      n_checks++;
      if (bus2.grant !== exp_g[i] || bus2.grant_id !== exp_id[i] || bus2.timeout !== exp_to[i] ||
          bus2.busy !== exp_bz[i] || bus2.heater_on !== 1'b0)
        $display("FAIL b2b cyc=%0d got=%b/%0d/%b/%b/%b exp=%b/%0d/%b/%b/0", i, bus2.grant, bus2.grant_id,
                 bus2.timeout, bus2.busy, bus2.heater_on, exp_g[i], exp_id[i], exp_to[i], exp_bz[i]);
      else n_pass++;
    end
    bus2.req = 3'b000;
    repeat (3) @(negedge clk);
  endtask

`ifdef HWA_TIMEOUT_STATS_EN
  task automatic test_timeout_stats();
    int seen;
    int cyc;
    reset_pulse();
    bus.req = 4'b0001;
    seen = 0;
    cyc  = 0;
    while (seen < 300 && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      if (bus.timeout) seen++;
    end
    n_checks++;
    if (seen != 300) $display("FAIL stats_pulses got=%0d exp=300", seen); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (timeout_count !== 8'd255) $display("FAIL stats_sat got=%0d exp=255", timeout_count); else n_pass++;
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    n_checks++;
    if (timeout_count !== 8'd0) $display("FAIL stats_clr got=%0d exp=0", timeout_count); else n_pass++;
    bus.req = 4'b0000;
    repeat (25) @(negedge clk);
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    bus.req  = '0;
    bus2.req = '0;
`ifdef HWA_TIMEOUT_STATS_EN
    clr_stats  = 1'b0;
    clr_stats2 = 1'b0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_no_preempt();
    test_drop_at_max();
    test_reset_mid_grant();
    test_back_to_back();
`ifdef HWA_TIMEOUT_STATS_EN
    test_timeout_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
